seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the 8-digit seven-segment display driver. It samples the multiplexed anode/cathode lines (`an`, `cath`) on the same clock, waits for each scanned digit to settle, and decodes the segment pattern back to ASCII plus decimal point. When all eight digits have been seen, it publishes a complete frame. It sits next to the display driver as an on-chip monitor and loopback checker, and the display benches use it as a scoreboard front end.

## Interface
- `SETTLE_CYCLES`, 4: consecutive cycles a registered `{an,cath}` pattern must hold before capture (≥1).
- `TIMEOUT_CYCLES`, 2_000_000: cycles without any capture before `stale` asserts.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `an` in 8: anode enables, active-low; bit k low selects digit k.
- `cath` in 8: segments, active-low; bit0=a … bit6=g, bit7=dp.
- `char_o` out 8×8 (packed `[7:0][7:0]`): decoded ASCII per digit, index = anode bit.
- `dp_o` out 8: decoded decimal point per digit (1 = lit).
- `frame_valid` out 1: one-cycle pulse; `char_o`/`dp_o` updated this cycle.
- `decode_err` out 1: one-cycle pulse on capture of an unmapped pattern.
- `multi_an_err` out 1: one-cycle pulse when the registered `an` has more than one bit low.
- `stale` out 1: level; no capture within `TIMEOUT_CYCLES`.

## Operation
- Input stage: `an`, `cath` registered once (`an_q`, `cath_q`). All further logic uses the registered values.
- Classification of `an_q`:
  - all ones = blank (ignored);
  - exactly one zero = valid digit k;
  - otherwise = multi-anode (error pulse on entry only, treated as blank).
- FSM states:
  - WAIT: no valid digit. Valid digit seen → SETTLE, counter = 1.
  - SETTLE: same `{an_q,cath_q}` → counter++. When counter reaches `SETTLE_CYCLES` → capture, go to HELD. Any change → SETTLE with counter = 1 if still valid, else WAIT.
  - HELD: pattern unchanged → stay with no recapture. Change → SETTLE/WAIT, same rule as above.
- Capture of digit k:
  - shadow[k] = decode(`cath_q[6:0]`); shadow_dp[k] = ~`cath_q[7]`; mask[k] = 1.
  - Recapturing a digit already in the mask overwrites that digit's shadow entry; the mask is unchanged.
- Decode map, active-low `cath[6:0]` → ASCII:
  - digits: 40→'0', 79→'1', 24→'2', 30→'3', 19→'4', 12→'5', 02→'6', 78→'7', 00→'8', 10→'9';
  - hex letters: 08→'A', 03→'b', 46→'C', 21→'d', 06→'E', 0E→'F';
  - symbols: 3F→'-', 7F→' ' (0x20);
  - any other pattern → '?' (0x3F) with a `decode_err` pulse.
- Frame completion: when a capture makes mask = FF:
  - copy the shadow (including this digit) to `char_o`/`dp_o`;
  - pulse `frame_valid`;
  - clear the mask.
- Stale counter:
  - cleared by every capture;
  - saturates at `TIMEOUT_CYCLES`;
  - `stale` = counter at saturation.

## Timing
- Reset values:
  - `char_o` all 0x20, `dp_o` 0;
  - `frame_valid`, `decode_err`, `multi_an_err`, `stale` all 0;
  - mask 0, state WAIT.
- Reset mid-frame discards the partial mask and the shadow.
- Latency: a pattern first present on `an`/`cath` before edge N appears in `an_q` after edge N. Capture occurs at edge N+`SETTLE_CYCLES`. `frame_valid`, `decode_err` and the new `char_o` are registered, so they are visible in the cycle after that edge.
- Simultaneous events:
  - a capture and a stale-counter saturation in the same cycle: the capture wins and `stale` stays 0;
  - a pattern change on the cycle the counter would reach `SETTLE_CYCLES`: no capture.
- `char_o`/`dp_o` change only together with `frame_valid`.

## Structure
- Package `seg_pkg`:
  - segment bit-position constants;
  - `seg_decode_t` struct {ascii, valid};
  - function `seg_to_ascii`;
  - FSM state enum;
  - shared with the display driver's encoder table.
- One sub-module, `seg_settle_filter`: input register, change detect, settle counter, and valid-digit/one-hot check. It emits `capture_stb` and `digit_idx`.

## Test plan
All scenarios use `SETTLE_CYCLES`=4.
1. Reset → `char_o` all 0x20, `dp_o`=00, all pulses 0, `stale`=0.
2. Scan digits 0..7 showing "01234567", each held 10 cycles → exactly one `frame_valid`. `char_o[0]`=0x30 … `char_o[7]`=0x37, `dp_o`=00.
3. Digit 3 held exactly 4 cycles → captured. A pattern held 3 cycles, then changed → not captured, mask bit unchanged.
4. `an`=FE with `cath`=0x7D (unmapped) held 6 cycles → one `decode_err` pulse, shadow[0]=0x3F. `cath`=0x40 with bit7 low → digit '0' and dp=1.
5. `an`=FC for 8 cycles → one `multi_an_err` pulse and no capture. Assert `rst` after 5 of 8 digits, then scan a full frame → a single `frame_valid` containing only post-reset data.
6. `TIMEOUT_CYCLES`=100 with `an` held FF → `stale`=1 at cycle 100. Next capture → `stale`=0 the following cycle.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//   Types, constants and the segment decode table for the seven-segment scan
//   decoder. The display driver's encoder uses the same bit positions and
//   character set, so both directions of the loopback agree on one table.
//
//   Contents:
//     SEG_A .. SEG_G, SEG_DP : bit positions inside the cathode byte
//     ASCII_BLANK / ASCII_UNKNOWN : characters for reset and unmapped codes
//     seg_decode_t           : {ascii, valid} result of a decode
//     scan_state_t           : settle FSM states
//     seg_to_ascii()         : active-low segment pattern -> ASCII
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] ASCII_BLANK   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    typedef struct packed {
        logic [7:0] ascii;
        logic       valid;
    } seg_decode_t;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } scan_state_t;

    // Segment patterns are active-low, so a lit segment is a 0 bit.
    // Anything outside the character set decodes to '?' with valid = 0.
    function automatic seg_decode_t seg_to_ascii(input logic [6:0] seg);
        seg_decode_t res;
        res.valid = 1'b1;
        res.ascii = ASCII_UNKNOWN;
        case (seg)
            7'h40:   res.ascii = 8'h30;
            7'h79:   res.ascii = 8'h31;
            7'h24:   res.ascii = 8'h32;
            7'h30:   res.ascii = 8'h33;
            7'h19:   res.ascii = 8'h34;
            7'h12:   res.ascii = 8'h35;
            7'h02:   res.ascii = 8'h36;
            7'h78:   res.ascii = 8'h37;
            7'h00:   res.ascii = 8'h38;
            7'h10:   res.ascii = 8'h39;
            7'h08:   res.ascii = 8'h41;
            7'h03:   res.ascii = 8'h62;
            7'h46:   res.ascii = 8'h43;
            7'h21:   res.ascii = 8'h64;
            7'h06:   res.ascii = 8'h45;
            7'h0E:   res.ascii = 8'h46;
            7'h3F:   res.ascii = 8'h2D;
            7'h7F:   res.ascii = ASCII_BLANK;
            default: begin
                res.ascii = ASCII_UNKNOWN;
                res.valid = 1'b0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_scan_if
//   Bundle between the multiplexed display lines and the scan decoder.
//
//   an, cath      : active-low anode enables and segment lines (driver side)
//   char_o, dp_o  : last complete frame, one ASCII byte + dp per digit
//   frame_valid   : one-cycle pulse when char_o/dp_o are refreshed
//   decode_err    : one-cycle pulse on capture of an unmapped pattern
//   multi_an_err  : one-cycle pulse when more than one anode goes low
//   stale         : level, no digit captured for the timeout period
//
//   master : the display side / bench that drives the lines
//   slave  : the decoder
// ---------------------------------------------------------------------------
interface seg_scan_if;

    logic [7:0]      an;
    logic [7:0]      cath;
    logic [7:0][7:0] char_o;
    logic [7:0]      dp_o;
    logic            frame_valid;
    logic            decode_err;
    logic            multi_an_err;
    logic            stale;

    modport master (
        output an,
        output cath,
        input  char_o,
        input  dp_o,
        input  frame_valid,
        input  decode_err,
        input  multi_an_err,
        input  stale
    );

    modport slave (
        input  an,
        input  cath,
        output char_o,
        output dp_o,
        output frame_valid,
        output decode_err,
        output multi_an_err,
        output stale
    );

endinterface

// File: rtl/seg_settle_filter.sv
// ---------------------------------------------------------------------------
// seg_settle_filter
//   Registers the raw anode/cathode lines, classifies the anode pattern and
//   runs the settle FSM. A digit is captured once its registered
//   {an,cath} pattern has been stable for SETTLE_CYCLES cycles; it is not
//   captured again until the pattern changes.
//
//   clk, rst      : clock, asynchronous active-high reset
//   an, cath      : raw active-low display lines
//   cath_q        : registered cathode byte, valid alongside capture_stb
//   capture_stb   : capture this digit on the coming edge
//   digit_idx     : digit number selected by the registered anode
//   multi_an_err  : registered pulse on entry into a multi-anode pattern
// ---------------------------------------------------------------------------
module seg_settle_filter
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] an,
    input  logic [7:0] cath,
    output logic [7:0] cath_q,
    output logic       capture_stb,
    output logic [2:0] digit_idx,
    output logic       multi_an_err
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_TARGET = CW'(SETTLE_CYCLES);

    logic [7:0]    an_q;
    logic [7:0]    an_p;
    logic [7:0]    cath_p;
    logic [CW-1:0] cnt;
    logic [CW-1:0] run_next;
    scan_state_t   state;
    logic          was_multi;
    logic          is_blank;
    logic          is_valid;
    logic          is_multi;
    logic          same;

    // Input register plus a one-cycle-older copy so a change in the
    // registered pattern can be seen without touching the raw inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q   <= 8'hFF;
            cath_q <= 8'hFF;
            an_p   <= 8'hFF;
            cath_p <= 8'hFF;
        end else begin
            an_q   <= an;
            cath_q <= cath;
            an_p   <= an_q;
            cath_p <= cath_q;
        end
    end

    assign is_blank = (an_q == 8'hFF);
    assign is_valid = $onehot(~an_q);
    assign is_multi = !is_blank && !is_valid;
    assign same     = ({an_q, cath_q} == {an_p, cath_p});

    // Only meaningful when exactly one anode is low.
    always_comb begin
        digit_idx = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!an_q[k]) begin
                digit_idx = 3'(k);
            end
        end
    end

    // Length of the stable run after this edge: any change restarts at 1.
    // HELD with an unchanged pattern is excluded from capture so a settled
    // digit is not captured again every cycle.
    always_comb begin
        run_next = CW'(1);
        if (state == ST_SETTLE && same) begin
            run_next = cnt + 1'b1;
        end
    end

    assign capture_stb = is_valid && !(state == ST_HELD && same)
                         && (run_next == SETTLE_TARGET);

    // Settle FSM. The counter never stores SETTLE_CYCLES itself: reaching it
    // is the capture, which moves straight to HELD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_WAIT;
            cnt   <= '0;
        end else if (!is_valid) begin
            state <= ST_WAIT;
            cnt   <= '0;
        end else if (capture_stb) begin
            state <= ST_HELD;
            cnt   <= '0;
        end else if (state == ST_HELD && same) begin
            state <= ST_HELD;
        end else begin
            state <= ST_SETTLE;
            cnt   <= run_next;
        end
    end

    // Multi-anode error fires once when the pattern enters that class, not
    // for every cycle it stays there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            was_multi    <= 1'b0;
            multi_an_err <= 1'b0;
        end else begin
            was_multi    <= is_multi;
            multi_an_err <= is_multi && !was_multi;
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//   Monitors the multiplexed lines of an 8-digit seven-segment display and
//   rebuilds the shown text. Each settled digit is decoded into a shadow
//   frame; once all eight digits have been captured the shadow is published
//   on char_o/dp_o together with a frame_valid pulse.
//
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seg_scan_if.slave (an/cath in, frame/status outputs)
//
//   SETTLE_CYCLES  : cycles a digit pattern must hold before capture (>= 1)
//   TIMEOUT_CYCLES : cycles without a capture before stale asserts
// ---------------------------------------------------------------------------
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic [7:0]      cath_q;
    logic            capture_stb;
    logic [2:0]      digit_idx;
    logic            multi_err;
    seg_decode_t     dec;

    logic [7:0][7:0] shadow;
    logic [7:0]      shadow_dp;
    logic [7:0]      mask;
    logic [7:0]      mask_next;
    logic            frame_done;
    logic [7:0][7:0] frame_chars;
    logic [7:0]      frame_dp;

    logic [7:0][7:0] char_q;
    logic [7:0]      dp_q;
    logic            frame_valid_q;
    logic            decode_err_q;
    logic [TW-1:0]   stale_cnt;

    seg_settle_filter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_filter (
        .clk          (clk),
        .rst          (rst),
        .an           (bus.an),
        .cath         (bus.cath),
        .cath_q       (cath_q),
        .capture_stb  (capture_stb),
        .digit_idx    (digit_idx),
        .multi_an_err (multi_err)
    );

    assign dec        = seg_to_ascii(cath_q[SEG_G:SEG_A]);
    assign mask_next  = mask | (8'h01 << digit_idx);
    assign frame_done = capture_stb && (mask_next == 8'hFF);

    // Shadow contents as they will be after this capture, so the digit that
    // completes the frame is published in the same edge.
    always_comb begin
        frame_chars            = shadow;
        frame_chars[digit_idx] = dec.ascii;
        frame_dp               = shadow_dp;
        frame_dp[digit_idx]    = ~cath_q[SEG_DP];
    end

    // Shadow frame, digit mask and the published frame. char_o/dp_o only
    // move on a frame completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow        <= {NUM_DIGITS{ASCII_BLANK}};
            shadow_dp     <= 8'h00;
            mask          <= 8'h00;
            char_q        <= {NUM_DIGITS{ASCII_BLANK}};
            dp_q          <= 8'h00;
            frame_valid_q <= 1'b0;
            decode_err_q  <= 1'b0;
        end else begin
            frame_valid_q <= frame_done;
            decode_err_q  <= capture_stb && !dec.valid;
            if (capture_stb) begin
                shadow    <= frame_chars;
                shadow_dp <= frame_dp;
                mask      <= frame_done ? 8'h00 : mask_next;
            end
            if (frame_done) begin
                char_q <= frame_chars;
                dp_q   <= frame_dp;
            end
        end
    end

    // Cycles since the last capture, saturating. Clearing on capture takes
    // priority so a capture on the saturating edge keeps stale low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_cnt <= '0;
        end else if (capture_stb) begin
            stale_cnt <= '0;
        end else if (stale_cnt != TIMEOUT_MAX) begin
            stale_cnt <= stale_cnt + 1'b1;
        end
    end

    assign bus.char_o       = char_q;
    assign bus.dp_o         = dp_q;
    assign bus.frame_valid  = frame_valid_q;
    assign bus.decode_err   = decode_err_q;
    assign bus.multi_an_err = multi_err;
    assign bus.stale        = (stale_cnt == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder
//   Drives directed and random scans into seg_scan_decoder and compares every
//   output, every cycle, with a reference model that reasons in terms of
//   input runs: a digit is taken once the same line pattern has been applied
//   for SETTLE cycles in a row, and the result shows one cycle later.
// ---------------------------------------------------------------------------
module tb_seg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst;

    seg_scan_if bus ();

    seg_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] decodeMap [int];
    logic [6:0] digitCode [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] mappedCodes [18] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                    7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                    7'h46, 7'h21, 7'h06, 7'h0E, 7'h3F, 7'h7F};

    // reference model state
    logic [15:0]     lastPat;
    int              runLen;
    bit              prevMulti;
    bit              pendCap;
    int              pendDigit;
    logic [7:0]      pendCath;
    bit              pendMulti;
    logic [7:0][7:0] shadowChar;
    logic [7:0]      shadowDp;
    logic [7:0]      seenMask;
    logic [7:0][7:0] expChar;
    logic [7:0]      expDp;
    int              sinceCapture;

    // observed pulse counters
    int frameCount;
    int decErrCount;
    int multiCount;

    // Compares one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int countZeros(input logic [7:0] a);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (!a[i]) n++;
        end
        return n;
    endfunction

    function automatic int zeroIdx(input logic [7:0] a);
        int idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (!a[i]) idx = i;
        end
        return idx;
    endfunction

    task automatic initMap();
        decodeMap[32'h40] = 8'h30; decodeMap[32'h79] = 8'h31;
        decodeMap[32'h24] = 8'h32; decodeMap[32'h30] = 8'h33;
        decodeMap[32'h19] = 8'h34; decodeMap[32'h12] = 8'h35;
        decodeMap[32'h02] = 8'h36; decodeMap[32'h78] = 8'h37;
        decodeMap[32'h00] = 8'h38; decodeMap[32'h10] = 8'h39;
        decodeMap[32'h08] = 8'h41; decodeMap[32'h03] = 8'h62;
        decodeMap[32'h46] = 8'h43; decodeMap[32'h21] = 8'h64;
        decodeMap[32'h06] = 8'h45; decodeMap[32'h0E] = 8'h46;
        decodeMap[32'h3F] = 8'h2D; decodeMap[32'h7F] = 8'h20;
    endtask

    task automatic resetModel();
        lastPat      = 16'hFFFF;
        runLen       = 0;
        prevMulti    = 1'b0;
        pendCap      = 1'b0;
        pendDigit    = 0;
        pendCath     = 8'hFF;
        pendMulti    = 1'b0;
        shadowChar   = {8{8'h20}};
        shadowDp     = 8'h00;
        seenMask     = 8'h00;
        expChar      = {8{8'h20}};
        expDp        = 8'h00;
        sinceCapture = 0;
    endtask

    // Asynchronous reset held for two edges, reset values checked, model
    // cleared; rst drops away from the clock edge.
    task automatic doReset();
        bus.an   = 8'hFF;
        bus.cath = 8'hFF;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_char_o", 64'(bus.char_o), {8{8'h20}});
        checkOutput("rst_dp_o", 64'(bus.dp_o), 64'h0);
        checkOutput("rst_frame_valid", 64'(bus.frame_valid), 64'h0);
        checkOutput("rst_decode_err", 64'(bus.decode_err), 64'h0);
        checkOutput("rst_multi_an_err", 64'(bus.multi_an_err), 64'h0);
        checkOutput("rst_stale", 64'(bus.stale), 64'h0);
        rst = 1'b0;
        resetModel();
    endtask

    // Applies one cycle of line values, advances the model by one edge and
    // checks every output after that edge.
    task automatic applyStimulus(input logic [7:0] an, input logic [7:0] cath);
        logic [15:0] pat;
        int          zeros;
        bit          nowCap;
        bit          nowMulti;
        bit          expFrame;
        bit          expDecErr;
        int          code;
        logic [7:0]  ch;

        bus.an   = an;
        bus.cath = cath;

        pat      = {an, cath};
        runLen   = (pat == lastPat) ? runLen + 1 : 1;
        lastPat  = pat;
        zeros    = countZeros(an);
        nowCap   = (zeros == 1) && (runLen == SETTLE);
        nowMulti = (zeros > 1) && !prevMulti;
        prevMulti = (zeros > 1);

        @(posedge clk);
        #1;

        expFrame  = 1'b0;
        expDecErr = 1'b0;
        if (pendCap) begin
            code = int'(pendCath[6:0]);
            if (decodeMap.exists(code)) begin
                ch = decodeMap[code];
            end else begin
                ch        = 8'h3F;
                expDecErr = 1'b1;
            end
            shadowChar[pendDigit] = ch;
            shadowDp[pendDigit]   = !pendCath[7];
            seenMask[pendDigit]   = 1'b1;
            if (seenMask == 8'hFF) begin
                expFrame = 1'b1;
                expChar  = shadowChar;
                expDp    = shadowDp;
                seenMask = 8'h00;
            end
            sinceCapture = 0;
        end else if (sinceCapture < TIMEOUT) begin
            sinceCapture++;
        end

        if (bus.frame_valid === 1'b1) frameCount++;
        if (bus.decode_err === 1'b1) decErrCount++;
        if (bus.multi_an_err === 1'b1) multiCount++;

        checkOutput("frame_valid", 64'(bus.frame_valid), 64'(expFrame));
        checkOutput("decode_err", 64'(bus.decode_err), 64'(expDecErr));
        checkOutput("multi_an_err", 64'(bus.multi_an_err), 64'(pendMulti));
        checkOutput("stale", 64'(bus.stale), 64'(sinceCapture == TIMEOUT));
        checkOutput("char_o", 64'(bus.char_o), 64'(expChar));
        checkOutput("dp_o", 64'(bus.dp_o), 64'(expDp));

        pendCap   = nowCap;
        pendDigit = zeroIdx(an);
        pendCath  = cath;
        pendMulti = nowMulti;
    endtask

    task automatic showDigit(input int k, input logic [7:0] cath, input int hold);
        for (int i = 0; i < hold; i++) begin
            applyStimulus(8'(~(8'h01 << k)), cath);
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) applyStimulus(8'hFF, 8'hFF);
    endtask

    initial begin
        rst      = 1'b1;
        bus.an   = 8'hFF;
        bus.cath = 8'hFF;
        initMap();
        resetModel();

        // reset state
        doReset();

        // "01234567", each digit held 10 cycles
        frameCount = 0;
        for (int k = 0; k < 8; k++) showDigit(k, {1'b1, digitCode[k]}, 10);
        blank(3);
        checkOutput("t2_frames", 64'(frameCount), 64'd1);
        checkOutput("t2_char_o", 64'(bus.char_o), 64'h3736353433323130);
        checkOutput("t2_dp_o", 64'(bus.dp_o), 64'h0);

        // exact settle boundary: 4 cycles captured, 3 cycles not
        doReset();
        frameCount = 0;
        showDigit(3, {1'b1, digitCode[3]}, 4);
        showDigit(5, {1'b1, digitCode[5]}, 3);
        blank(2);
        showDigit(0, {1'b1, digitCode[0]}, 6);
        showDigit(1, {1'b1, digitCode[1]}, 6);
        showDigit(2, {1'b1, digitCode[2]}, 6);
        showDigit(4, {1'b1, digitCode[4]}, 6);
        showDigit(6, {1'b1, digitCode[6]}, 6);
        showDigit(7, {1'b1, digitCode[7]}, 6);
        blank(2);
        checkOutput("t3_no_frame_without_5", 64'(frameCount), 64'd0);
        showDigit(5, {1'b1, digitCode[5]}, 6);
        blank(2);
        checkOutput("t3_frame_after_5", 64'(frameCount), 64'd1);
        checkOutput("t3_char3", 64'(bus.char_o[3]), 64'h33);
        checkOutput("t3_char5", 64'(bus.char_o[5]), 64'h35);

        // unmapped pattern, then decimal point
        doReset();
        decErrCount = 0;
        applyStimulus(8'hFE, 8'h7D);
        repeat (5) applyStimulus(8'hFE, 8'h7D);
        blank(2);
        checkOutput("t4_decode_err_pulses", 64'(decErrCount), 64'd1);
        for (int k = 1; k < 8; k++) showDigit(k, {1'b1, digitCode[k]}, 5);
        blank(2);
        checkOutput("t4_char0_unknown", 64'(bus.char_o[0]), 64'h3F);
        showDigit(0, 8'h40, 6);
        for (int k = 1; k < 8; k++) showDigit(k, {1'b1, digitCode[k]}, 5);
        blank(2);
        checkOutput("t4_char0_zero", 64'(bus.char_o[0]), 64'h30);
        checkOutput("t4_dp0", 64'(bus.dp_o[0]), 64'h1);

        // multi-anode, then reset in the middle of a frame
        doReset();
        multiCount = 0;
        repeat (8) applyStimulus(8'hFC, 8'h40);
        blank(2);
        checkOutput("t5_multi_pulses", 64'(multiCount), 64'd1);
        for (int k = 3; k < 8; k++) showDigit(k, {1'b1, digitCode[8]}, 6);
        doReset();
        frameCount = 0;
        for (int k = 0; k < 8; k++) showDigit(k, {1'b1, digitCode[k]}, 6);
        blank(2);
        checkOutput("t5_frames_after_reset", 64'(frameCount), 64'd1);
        checkOutput("t5_char_o", 64'(bus.char_o), 64'h3736353433323130);

        // stale timeout and its clearing
        doReset();
        blank(99);
        checkOutput("t6_stale_at_99", 64'(bus.stale), 64'h0);
        blank(1);
        checkOutput("t6_stale_at_100", 64'(bus.stale), 64'h1);
        showDigit(2, {1'b1, digitCode[2]}, 4);
        checkOutput("t6_stale_before_capture", 64'(bus.stale), 64'h1);
        applyStimulus(8'hFB, {1'b1, digitCode[2]});
        checkOutput("t6_stale_cleared", 64'(bus.stale), 64'h0);

        // capture on the same edge the counter would saturate
        doReset();
        blank(95);
        showDigit(6, {1'b1, digitCode[6]}, 4);
        applyStimulus(8'hBF, {1'b1, digitCode[6]});
        checkOutput("t6_capture_beats_stale", 64'(bus.stale), 64'h0);

        // random scanning
        doReset();
        for (int s = 0; s < 700; s++) begin
            int         r;
            int         k;
            logic [6:0] code;
            logic [7:0] anv;
            r = $urandom_range(99);
            if (r < 1) begin
                doReset();
            end else if (r < 75) begin
                k = $urandom_range(7);
                if ($urandom_range(9) < 8) code = mappedCodes[$urandom_range(17)];
                else code = 7'($urandom);
                showDigit(k, {1'($urandom_range(1)), code}, $urandom_range(1, 8));
            end else if (r < 90) begin
                blank($urandom_range(1, 3));
            end else begin
                do anv = 8'($urandom); while (countZeros(anv) < 2);
                code = 7'($urandom);
                for (int i = 0; i < $urandom_range(1, 4); i++) applyStimulus(anv, {1'b1, code});
            end
        end
        blank(4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
